// File: rtl/prog_loader_if.sv
// Command channel between the host/test harness and the program loader:
// a symbolic instruction plus its valid/ready handshake.
interface prog_loader_if #(parameter int ADDR_W = 10);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_kind;
  logic [2:0]        alu_op;
  logic [15:0]       inm;
  logic [3:0]        ra;
  logic [3:0]        rb;
  logic [3:0]        rd;
  logic [ADDR_W-1:0] target;

  modport master (
    output cmd_valid, cmd_kind, alu_op, inm, ra, rb, rd, target,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_kind, alu_op, inm, ra, rb, rd, target,
    output cmd_ready
  );
endinterface

// File: rtl/prog_loader.sv
// Sequential program-memory writer: encodes symbolic commands into 32-bit
// instruction words at consecutive addresses while holding the CPU in reset.
module prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      cmd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words
);

  localparam logic [2:0] K_ALU_REG = 3'd0;
  localparam logic [2:0] K_ALU_INM = 3'd1;
  localparam logic [2:0] K_JMP_ABS = 3'd2;
  localparam logic [2:0] K_JMP_REL = 3'd3;
  localparam logic [2:0] K_JZ      = 3'd4;
  localparam logic [2:0] K_END     = 3'd6;
  localparam logic [2:0] K_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;
  state_t state;

  // Immediate-form ALU ops use a 4-bit nibble; only 001 and 110 are remapped.
  function automatic logic [3:0] inm_nib(input logic [2:0] op);
    case (op)
      3'b001:  inm_nib = 4'b0110;
      3'b110:  inm_nib = 4'b0111;
      default: inm_nib = {1'b0, op};
    endcase
  endfunction

  function automatic logic [7:0] jmp_opcode(input logic [2:0] kind);
    case (kind)
      K_JMP_ABS: jmp_opcode = 8'h15;
      K_JMP_REL: jmp_opcode = 8'h16;
      K_JZ:      jmp_opcode = 8'h17;
      default:   jmp_opcode = 8'h18;
    endcase
  endfunction

  function automatic logic [31:0] encode(
    input logic [2:0]  kind,
    input logic [2:0]  op,
    input logic [15:0] imm,
    input logic [3:0]  a,
    input logic [3:0]  b,
    input logic [3:0]  d,
    input logic [23:0] tgt
  );
    case (kind)
      K_ALU_REG: encode = {1'b1, op, 16'h0000, a, b, d};
      K_ALU_INM: encode = {inm_nib(op), imm, 4'h0, b, d};
      default:   encode = {jmp_opcode(kind), tgt};
    endcase
  endfunction

  logic        accept;
  logic        full;
  logic        bad_cmd;
  logic [23:0] target_ext;

  assign accept     = (state == S_LOAD) && cmd.cmd_valid;
  assign full       = words[ADDR_W];
  assign bad_cmd    = (cmd.cmd_kind == K_ILLEGAL) ||
                      ((cmd.cmd_kind == K_ALU_INM) && (cmd.alu_op == 3'b111)) ||
                      full;
  assign target_ext = 24'(cmd.target);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cmd.cmd_ready <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words         <= '0;
    end else begin
      mem_we <= 1'b0;
      // start has priority: any command in the same cycle is dropped.
      if (start) begin
        state         <= S_LOAD;
        cmd.cmd_ready <= 1'b1;
        cpu_hold      <= 1'b1;
        done          <= 1'b0;
        error         <= 1'b0;
        words         <= '0;
      end else if (accept) begin
        if (cmd.cmd_kind == K_END) begin
          state         <= S_DONE;
          cmd.cmd_ready <= 1'b0;
          cpu_hold      <= 1'b0;
          done          <= 1'b1;
        end else if (bad_cmd) begin
          state         <= S_ERROR;
          cmd.cmd_ready <= 1'b0;
          error         <= 1'b1;
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= words[ADDR_W-1:0];
          mem_wdata <= encode(cmd.cmd_kind, cmd.alu_op, cmd.inm,
                              cmd.ra, cmd.rb, cmd.rd, target_ext);
          words     <= words + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a 1024-word instance and a 4-word instance
// share one command stream and are checked against a behavioural model.
module tb_prog_loader;
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic v = 1'b0;
  logic [2:0] k = '0, op = '0;
  logic [15:0] imm = '0;
  logic [3:0] ra = '0, rb = '0, rd = '0;
  logic [9:0] tgt = '0;

  logic we_a, hold_a, done_a, err_a, we_b, hold_b, done_b, err_b;
  logic [9:0] addr_a;
  logic [1:0] addr_b;
  logic [31:0] wd_a, wd_b;
  logic [10:0] words_a;
  logic [2:0] words_b;

  prog_loader_if #(.ADDR_W(10)) if_a ();
  prog_loader_if #(.ADDR_W(2))  if_b ();

  assign if_a.cmd_valid = v;  assign if_b.cmd_valid = v;
  assign if_a.cmd_kind = k;   assign if_b.cmd_kind = k;
  assign if_a.alu_op = op;    assign if_b.alu_op = op;
  assign if_a.inm = imm;      assign if_b.inm = imm;
  assign if_a.ra = ra;        assign if_b.ra = ra;
  assign if_a.rb = rb;        assign if_b.rb = rb;
  assign if_a.rd = rd;        assign if_b.rd = rd;
  assign if_a.target = tgt;   assign if_b.target = tgt[1:0];

  prog_loader #(.ADDR_W(10)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .cmd(if_a.slave),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
    .cpu_hold(hold_a), .done(done_a), .error(err_a), .words(words_a)
  );

  prog_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .cmd(if_b.slave),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
    .cpu_hold(hold_b), .done(done_b), .error(err_b), .words(words_b)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t q[2][$];
  int mode[2];
  int mwords[2];
  int depth[2] = '{1024, 4};
  int checks = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Instruction word computed arithmetically from the field layout.
  function automatic logic [31:0] expect_word(int kind, int o, int i, int a, int b, int d, int t);
    int nib_tab[8] = '{0, 6, 2, 3, 4, 5, 7, 0};
    longint w;
    if (kind == 0)
      w = 64'd2147483648 + longint'(o) * 268435456 + a * 256 + b * 16 + d;
    else if (kind == 1)
      w = longint'(nib_tab[o]) * 268435456 + longint'(i) * 4096 + b * 16 + d;
    else
      w = longint'(21 + kind - 2) * 16777216 + t;
    return w[31:0];
  endfunction

  task automatic model_edge(int d);
    logic s, r;
    wr_t e;
    s = (d == 0) ? start_a : start_b;
    r = (d == 0) ? rst_a : rst_b;
    if (r) return;
    if (s) begin
      mode[d] = M_LOAD;
      mwords[d] = 0;
    end else if (mode[d] == M_LOAD && v) begin
      if (k == 6)
        mode[d] = M_DONE;
      else if (k == 7 || (k == 1 && op == 7) || mwords[d] == depth[d])
        mode[d] = M_ERR;
      else begin
        e.addr = mwords[d];
        e.data = expect_word(int'(k), int'(op), int'(imm), int'(ra), int'(rb),
                             int'(rd), int'(tgt) % depth[d]);
        q[d].push_back(e);
        mwords[d]++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic set_cmd(int kind, int o, int i, int a, int b, int d, int t);
    k = 3'(kind); op = 3'(o); imm = 16'(i); ra = 4'(a); rb = 4'(b); rd = 4'(d);
    tgt = 10'(t); v = 1'b1;
  endtask

  task automatic issue(int kind, int o, int i, int a, int b, int d, int t);
    set_cmd(kind, o, i, a, b, d, t);
    cycle();
  endtask

  task automatic issue_rand(int kind);
    issue(kind, $urandom_range(0, 7), $urandom_range(0, 65535), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1023));
  endtask

  task automatic idle(int n);
    v = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic pulse_start(int d);
    if (d == 0) start_a = 1'b1; else start_b = 1'b1;
    cycle();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic check_status(int d);
    logic r, h, dn, er;
    logic [63:0] w;
    if (d == 0) begin
      r = if_a.cmd_ready; h = hold_a; dn = done_a; er = err_a; w = 64'(words_a);
    end else begin
      r = if_b.cmd_ready; h = hold_b; dn = done_b; er = err_b; w = 64'(words_b);
    end
    chk($sformatf("cmd_ready%0d", d), 64'(r), 64'(mode[d] == M_LOAD));
    chk($sformatf("cpu_hold%0d", d), 64'(h), 64'(mode[d] == M_LOAD || mode[d] == M_ERR));
    chk($sformatf("done%0d", d), 64'(dn), 64'(mode[d] == M_DONE));
    chk($sformatf("error%0d", d), 64'(er), 64'(mode[d] == M_ERR));
    chk($sformatf("words%0d", d), w, 64'(mwords[d]));
  endtask

  task automatic check_reset_a();
    chk("rst_mem_we", 64'(we_a), 64'd0);
    chk("rst_mem_addr", 64'(addr_a), 64'd0);
    chk("rst_mem_wdata", 64'(wd_a), 64'd0);
    check_status(0);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (we_a) begin
      if (q[0].size() == 0) begin
        checks++; fails++;
        $display("FAIL write_a: unexpected write addr=%0d data=%h, expected none", addr_a, wd_a);
      end else begin
        e = q[0].pop_front();
        chk("mem_addr_a", 64'(addr_a), 64'(e.addr));
        chk("mem_wdata_a", 64'(wd_a), 64'(e.data));
      end
    end
    if (we_b) begin
      if (q[1].size() == 0) begin
        checks++; fails++;
        $display("FAIL write_b: unexpected write addr=%0d data=%h, expected none", addr_b, wd_b);
      end else begin
        e = q[1].pop_front();
        chk("mem_addr_b", 64'(addr_b), 64'(e.addr));
        chk("mem_wdata_b", 64'(wd_b), 64'(e.data));
      end
    end
  end

  initial begin
    int n;
    mode = '{M_IDLE, M_IDLE};
    mwords = '{0, 0};
    #2 rst_a = 1'b1; rst_b = 1'b1;
    #10 check_reset_a();
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // start with a command in the same cycle: only the next one is taken
    set_cmd(0, 2, 0, 1, 2, 3, 0);
    pulse_start(0);
    check_status(0);
    issue(0, 2, 0, 1, 2, 3, 0);
    check_status(0);
    idle(2);

    // ALU_INM then JZ back-to-back, then END
    pulse_start(0);
    issue(1, 2, 2, 0, 1, 3, 0);
    issue(4, 0, 0, 0, 0, 0, 5);
    issue(6, 0, 0, 0, 0, 0, 0);
    check_status(0);
    idle(2);
    check_status(0);

    // illegal commands
    pulse_start(0);
    issue(1, 7, 100, 0, 1, 2, 0);
    check_status(0);
    idle(1);
    pulse_start(0);
    issue_rand(0);
    issue(7, 0, 0, 0, 0, 0, 0);
    check_status(0);
    issue(6, 0, 0, 0, 0, 0, 0);
    check_status(0);

    // small memory: fill, overflow, restart
    pulse_start(1);
    repeat (4) issue_rand(0);
    check_status(1);
    issue_rand(0);
    check_status(1);
    idle(2);
    check_status(1);
    pulse_start(1);
    check_status(1);
    issue_rand(2);
    check_status(1);
    pulse_start(1);
    repeat (4) issue_rand(3);
    issue(6, 0, 0, 0, 0, 0, 0);
    check_status(1);
    idle(1);

    // restart mid-load while a write strobe is in flight
    pulse_start(0);
    issue_rand(0);
    issue_rand(1);
    pulse_start(0);
    check_status(0);
    issue(3, 0, 0, 0, 0, 0, 777);
    check_status(0);

    // async reset in the cycle after an accepted command
    issue_rand(5);
    rst_a = 1'b1;
    #1;
    mode[0] = M_IDLE;
    mwords[0] = 0;
    q[0].delete();
    check_reset_a();
    idle(1);
    rst_a = 1'b0;
    pulse_start(0);
    issue_rand(0);
    check_status(0);
    idle(1);

    // randomized loads
    for (int ld = 0; ld < 10; ld++) begin
      pulse_start(0);
      n = $urandom_range(3, 25);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        if ($urandom_range(0, 19) == 0) issue_rand(7);
        else issue_rand($urandom_range(0, 5));
      end
      case ($urandom_range(0, 2))
        0: issue_rand(6);
        1: issue_rand(7);
        default: issue(1, 7, 0, 0, 0, 0, 0);
      endcase
      check_status(0);
      idle($urandom_range(1, 3));
      check_status(0);
    end

    idle(3);
    chk("pending_a", 64'(q[0].size()), 64'd0);
    chk("pending_b", 64'(q[1].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Sequential writer for the CPU's program memory. It accepts symbolic instruction commands over a valid/ready handshake and encodes each one into the 32-bit instruction word that the control unit decodes. Words are written to consecutive program-memory addresses starting at 0, and the CPU is held in reset until loading finishes. It sits between the host/test harness and the instruction memory of the single-cycle CPU.

## Interface
Parameters:
- ADDR_W, 10: program-memory address width; depth is 2^ADDR_W words; legal range 1..24.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle pulse that starts (or restarts) a load at address 0.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_kind  in  3  command kind:
  - 0: ALU_REG
  - 1: ALU_INM
  - 2: JMP_ABS
  - 3: JMP_REL
  - 4: JZ
  - 5: JNZ
  - 6: END
  - 7: illegal
- alu_op  in  3  ALU operation code.
- inm  in  16  immediate value.
- ra, rb, rd  in  4 each  register fields.
- target  in  ADDR_W  jump target.
- mem_we  out  1  program-memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded instruction word.
- cpu_hold  out  1  holds the CPU in reset while asserted.
- done  out  1  load finished cleanly.
- error  out  1  load aborted.
- words  out  ADDR_W+1  number of words written in the current or last load.

## Operation
States:
- IDLE
  - Reset state.
  - cmd_ready=0, cpu_hold=0.
  - start moves to LOAD.
- LOAD
  - cmd_ready=1, cpu_hold=1.
  - A command is accepted when cmd_valid and cmd_ready are both high at a clock edge.
- DONE
  - done=1, cpu_hold=0, cmd_ready=0.
  - start moves to LOAD.
- ERROR
  - error=1, cpu_hold=1, cmd_ready=0.
  - Only start or reset leaves this state.

Entering LOAD (from any state via start):
- words cleared to 0.
- done and error cleared.
- Any command presented in the same cycle is ignored, not accepted.

Encoding of legal commands (bit 31 is the MSB):
- ALU_REG: {1'b1, alu_op, 16'h0000, ra, rb, rd}. All eight alu_op values are legal.
- ALU_INM: {nib, inm, 4'h0, rb, rd}. The 3-bit alu_op maps to the 4-bit nibble nib as follows:
  - 000→0000
  - 010→0010
  - 011→0011
  - 100→0100
  - 101→0101
  - 001→0110
  - 110→0111
  - alu_op 111 is illegal.
- Jumps: {opcode8, zero pad, target}, with target zero-extended to 24 bits. The opcode byte is:
  - JMP_ABS: 0x15
  - JMP_REL: 0x16
  - JZ: 0x17
  - JNZ: 0x18
- END: no word is written. Transition to DONE; words keeps its value.

Error conditions (no write, transition to ERROR):
- cmd_kind=7.
- ALU_INM with alu_op=111.
- A non-END command accepted when words == 2^ADDR_W (memory full).
- END is still legal when memory is full.

In ERROR, words holds the count of words written before the abort. Words already written are left in memory; the block does not clean them up.

## Timing
- Reset values: state=IDLE, cmd_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0, words=0.
- All outputs are registered.
- Write latency:
  - A command accepted at edge k produces mem_we=1 for exactly one cycle, starting after edge k.
  - During that cycle, mem_addr equals the words value before the command and mem_wdata holds the encoded word.
  - words increments at edge k.
  - Throughput is one command per cycle. Back-to-back writes use consecutive addresses.
- State transitions:
  - cmd_ready drops in the cycle after an END or an error command is accepted.
  - done or error asserts in that same cycle.
  - cpu_hold deasserts in that same cycle after END.
- start while in LOAD:
  - Restarts the load. The next accepted command writes address 0.
  - A write strobe already scheduled by the previous edge still completes.
- Asynchronous reset mid-load:
  - Returns immediately to the reset values, including mem_we=0.
  - Any pending write is lost.
- cmd_valid high while cmd_ready is low has no effect.

## Test plan
- ALU_REG, alu_op=010, ra=1, rb=2, rd=3 → mem_we for one cycle, addr 0, wdata 0xA0000123; words=1.
- ALU_INM, alu_op=010, inm=2, rb=1, rd=3, then JZ with target=5 (ADDR_W=10) → back-to-back writes:
  - addr 0: 0x20002013
  - addr 1: 0x17000005
- Then END → done=1, cpu_hold=0, words=2.
- ADDR_W=2: four ALU_REG commands fill addresses 0..3, then a fifth command arrives → no write, error=1, cpu_hold=1, words=4. A following start clears error and begins a new load at address 0.
- ALU_INM with alu_op=111, and separately cmd_kind=7 → no mem_we, error=1, cmd_ready=0.
- Assert reset during LOAD in the cycle after an accepted command → mem_we=0 immediately and all outputs at reset values. A new start then loads from address 0.
- start asserted together with cmd_valid in IDLE → the command is not accepted; the first word is written only for a command presented in the next cycle, at address 0.
